// File: rtl/mode_decider_chroma8x8.sv
// Chroma 8x8 intra mode decider: sums Cb+Cr SAD triplets per mode and picks the cheapest (DC/H/V).
// Optional CHROMA_MODE_BIAS_EN adds NON_DC_BIAS to the H and V costs before comparison.
module mode_decider_chroma8x8 #(
  parameter int SAD_W       = 8,
  parameter int COST_W      = SAD_W + 1,
  parameter int MB_IDX_W    = 16,
  parameter int NON_DC_BIAS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_cr,
  input  logic [SAD_W-1:0]    sad_v,
  input  logic [SAD_W-1:0]    sad_h,
  input  logic [SAD_W-1:0]    sad_dc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          best_mode,
  output logic [COST_W-1:0]   best_cost,
  output logic [MB_IDX_W-1:0] mb_idx,
  output logic                order_err
);

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_V  = 2'd2;
  localparam logic [COST_W-1:0] COST_MAX = '1;
`ifdef CHROMA_MODE_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif
  localparam logic [COST_W-1:0] BIAS = BIAS_ON ? COST_W'(NON_DC_BIAS) : '0;

  typedef enum logic [1:0] {WAIT_CB, WAIT_CR, DECIDE, HOLD} state_t;

  state_t state, state_nxt;
  logic   load_cb, add_cr, set_err, do_decide, accept;
  logic [COST_W-1:0] acc_v, acc_h, acc_dc;
  logic [COST_W-1:0] ext_v, ext_h, ext_dc;
  logic [COST_W-1:0] cost_v, cost_h, cost_dc, cost_sel;
  logic [1:0]        mode_sel;

  function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                input logic [COST_W-1:0] b);
    logic [COST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COST_W] ? COST_MAX : s[COST_W-1:0];
  endfunction

  assign ext_v  = {{(COST_W-SAD_W){1'b0}}, sad_v};
  assign ext_h  = {{(COST_W-SAD_W){1'b0}}, sad_h};
  assign ext_dc = {{(COST_W-SAD_W){1'b0}}, sad_dc};

  // DC is never biased; the bias is zero unless the feature is enabled.
  assign cost_dc = acc_dc;
  assign cost_h  = sat_add(acc_h, BIAS);
  assign cost_v  = sat_add(acc_v, BIAS);

  // Earlier mode keeps the win on ties: only a strictly lower cost displaces it.
  always_comb begin
    mode_sel = MODE_DC;
    cost_sel = cost_dc;
    if (cost_h < cost_sel) begin
      mode_sel = MODE_H;
      cost_sel = cost_h;
    end
    if (cost_v < cost_sel) begin
      mode_sel = MODE_V;
      cost_sel = cost_v;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_cb   = 1'b0;
    add_cr    = 1'b0;
    set_err   = 1'b0;
    do_decide = 1'b0;
    accept    = 1'b0;
    case (state)
      WAIT_CB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_is_cr) begin
            load_cb   = 1'b1;
            state_nxt = WAIT_CR;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      WAIT_CR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_is_cr) begin
            add_cr    = 1'b1;
            state_nxt = DECIDE;
          end else begin
            // A second Cb restarts the macroblock with the new plane.
            set_err = 1'b1;
            load_cb = 1'b1;
          end
        end
      end
      DECIDE: begin
        do_decide = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          accept    = 1'b1;
          state_nxt = WAIT_CB;
        end
      end
      default: state_nxt = WAIT_CB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_CB;
      acc_v     <= '0;
      acc_h     <= '0;
      acc_dc    <= '0;
      out_valid <= 1'b0;
      best_mode <= MODE_DC;
      best_cost <= '0;
      mb_idx    <= '0;
      order_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_cb) begin
        acc_v  <= ext_v;
        acc_h  <= ext_h;
        acc_dc <= ext_dc;
      end else if (add_cr) begin
        acc_v  <= sat_add(acc_v, ext_v);
        acc_h  <= sat_add(acc_h, ext_h);
        acc_dc <= sat_add(acc_dc, ext_dc);
      end else if (accept) begin
        acc_v  <= '0;
        acc_h  <= '0;
        acc_dc <= '0;
      end
      if (do_decide) begin
        best_mode <= mode_sel;
        best_cost <= cost_sel;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
        mb_idx    <= mb_idx + MB_IDX_W'(1);
      end
      if (set_err) order_err <= 1'b1;
    end
  end

endmodule

// File: doc/mode_decider_chroma8x8.md
Name: mode_decider_chroma8x8

Overview:
- Sits directly downstream of the chroma 8x8 SAD stage.
- Takes one SAD triplet (V, H, DC) per chroma plane, Cb first and then Cr, and sums the two planes per mode.
- Selects the lowest-cost intra chroma mode and reports it with its cost to the macroblock mode/reconstruction control.
- Uses valid/ready handshakes on both sides; one decision per macroblock.

Parameters:
- SAD_W, 8, width of each input SAD.
- COST_W, SAD_W+1, width of the summed per-mode cost. Must be >= SAD_W+1.
- MB_IDX_W, 16, width of the macroblock decision counter.
- NON_DC_BIAS, 4, constant added to H and V costs when CHROMA_MODE_BIAS_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  SAD triplet valid
- in_ready  out  1  block can accept a triplet
- in_is_cr  in  1  0 = Cb triplet, 1 = Cr triplet
- sad_v  in  SAD_W  vertical-mode SAD
- sad_h  in  SAD_W  horizontal-mode SAD
- sad_dc  in  SAD_W  DC-mode SAD
- out_valid  out  1  decision valid
- out_ready  in  1  consumer accepts decision
- best_mode  out  2  chosen mode: 0 = DC, 1 = H, 2 = V (H.264 chroma coding; 3 never produced)
- best_cost  out  COST_W  cost of the chosen mode
- mb_idx  out  MB_IDX_W  count of decisions accepted since reset
- order_err  out  1  sticky flag for a plane-order violation

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - state = WAIT_CB; out_valid = 0; best_mode = 0; best_cost = 0; mb_idx = 0; order_err = 0.
  - Internal accumulators are cleared.
  - Reset mid-operation discards any partially received macroblock.
- in_ready = 1 in WAIT_CB and WAIT_CR only. A transfer occurs on a cycle with in_valid && in_ready.
- WAIT_CB:
  - A transfer with in_is_cr = 0 latches the zero-extended sad_v/sad_h/sad_dc into acc_v/acc_h/acc_dc, then goes to WAIT_CR.
  - A transfer with in_is_cr = 1 is dropped, sets order_err, and the state stays WAIT_CB.
- WAIT_CR:
  - A transfer with in_is_cr = 1 adds each SAD into its accumulator, then goes to DECIDE.
  - A transfer with in_is_cr = 0 sets order_err and restarts the macroblock: the accumulators are overwritten with the new Cb values and the state stays WAIT_CR.
- Accumulation saturates at 2^COST_W-1. With the default COST_W it cannot overflow.
- DECIDE (exactly one cycle):
  - Compares the three costs. Ties resolve in the order DC, then H, then V: a strictly lower cost is needed to displace the earlier mode.
  - Registers best_mode and best_cost, sets out_valid = 1, and goes to HOLD.
- Latency: out_valid rises 2 cycles after the Cr transfer cycle (the Cr accept edge, then the DECIDE edge).
- HOLD:
  - best_mode, best_cost, and out_valid stay stable until out_valid && out_ready.
  - On that cycle: out_valid clears, mb_idx increments (wrapping at 2^MB_IDX_W), the state returns to WAIT_CB, and the accumulators clear.
  - in_ready = 0 throughout HOLD, so no new triplet overlaps with a pending decision.
  - out_ready already high when HOLD is entered gives acceptance on the first HOLD cycle. Peak throughput is one macroblock per 4 cycles.
- order_err clears only on reset.
- in_is_cr and the SAD inputs are ignored when no transfer occurs.

Optional Feature:
- Macro: CHROMA_MODE_BIAS_EN.
- Defined:
  - In DECIDE, the H and V costs used for comparison and reported in best_cost are acc + NON_DC_BIAS, saturated at 2^COST_W-1.
  - DC is never biased, which favours DC for flat chroma.
- Undefined:
  - Raw sums are used. The NON_DC_BIAS parameter is present but has no effect.

Test Plan:
- Basic decision: Cb (v=10, h=20, dc=30), Cr (v=5, h=5, dc=5), out_ready = 1 -> best_mode = 2, best_cost = 15, out_valid exactly 2 cycles after the Cr transfer, mb_idx 0 -> 1.
- Tie-break: Cb (8,8,8), Cr (2,2,2) -> best_mode = 0, cost 10. Cb (v=4, h=3, dc=9), Cr (v=0, h=1, dc=0) -> H and V tie at 4 -> best_mode = 1.
- Backpressure: out_ready = 0 for 5 cycles after out_valid, with in_valid held high and a new Cb presented -> in_ready = 0 and outputs stable throughout; the new Cb is accepted only after the handshake; mb_idx increments once.
- Order error: Cr sent first -> order_err = 1, input dropped. Then Cb (1,1,1), Cb (50,60,70), Cr (0,0,0) -> decision uses the second Cb: mode 2, cost 50; order_err stays 1.
- Saturation/width: SAD_W = 8, both planes (255,255,255) -> cost 510 and best_mode = 0. With CHROMA_MODE_BIAS_EN, NON_DC_BIAS = 4: Cb (10,10,12), Cr (0,0,0) -> DC cost 12 vs H/V 14 -> best_mode = 0, cost 12.
- Reset mid-frame: reset asserted in WAIT_CR, then a fresh Cb (7,9,9) and Cr (0,0,0) -> best_mode = 2, cost 7, mb_idx 0 -> 1, no trace of the pre-reset data.
